fas_frame_sched: RTL

- Frame scheduler between the FIR filter and the 16-point FFT engine inside FAS.
- Packs the FIR output stream into 16-sample frames using a two-bank ping-pong buffer.
- Sequences one FFT run per full frame and serves the FFT its samples through a random-access read port.
- After N_FRAME frames it triggers the frequency-analysis stage and raises done.

---
 rtl/fas_frame_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/fas_frame_sched.sv
// Frame scheduler between the FIR filter and the 16-point FFT: packs samples into a ping-pong
// buffer, sequences one FFT run per full frame and starts frequency analysis after NFrame frames.
module fas_frame_sched #(
  parameter int unsigned NPoint = 16,
  parameter int unsigned DataW  = 16,
  parameter int unsigned NFrame = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      fir_valid_i,
  input  logic [DataW-1:0]          fir_d_i,
  input  logic                      fft_ready_i,
  output logic                      fft_start_o,
  input  logic [$clog2(NPoint)-1:0] fft_rd_addr_i,
  output logic [DataW-1:0]          fft_rd_data_o,
  input  logic                      fft_done_i,
  output logic                      ana_start_o,
  input  logic                      ana_done_i,
  output logic [3:0]                frame_cnt_o,
  output logic                      overflow_o,
  output logic                      done_o
);

  localparam int unsigned AddrW  = $clog2(NPoint);
  localparam int unsigned FrameW = $clog2(NFrame + 1);
  localparam logic [AddrW-1:0]  LastIdx   = AddrW'(NPoint - 1);
  localparam logic [FrameW-1:0] NFrameWr  = FrameW'(NFrame);
  localparam logic [3:0]        NFrameCnt = 4'(NFrame);

  typedef enum logic [1:0] {StIdle, StRun, StAna, StDone} state_e;

  state_e            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [AddrW-1:0]  wr_idx_q, wr_idx_d;
  logic [1:0]        full_q, full_d;
  logic [FrameW-1:0] frames_wr_q, frames_wr_d;
  logic [3:0]        frame_cnt_q, frame_cnt_d;
  logic              overflow_q, overflow_d;
  logic              fft_start_q, fft_start_d;
  logic              ana_start_q, ana_start_d;
  logic              wr_en;

  // Sample storage is deliberately left out of reset.
  logic [DataW-1:0] mem_q [2][NPoint];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_bank_q][wr_idx_q] <= fir_d_i;
    end
  end

  assign fft_rd_data_o = mem_q[rd_bank_q][fft_rd_addr_i];

  always_comb begin
    wr_bank_d   = wr_bank_q;
    wr_idx_d    = wr_idx_q;
    frames_wr_d = frames_wr_q;
    full_d      = full_q;
    overflow_d  = overflow_q;
    wr_en       = 1'b0;
    state_d     = state_q;
    rd_bank_d   = rd_bank_q;
    frame_cnt_d = frame_cnt_q;
    fft_start_d = 1'b0;
    ana_start_d = 1'b0;

    if (fir_valid_i && (frames_wr_q < NFrameWr) && (state_q != StDone)) begin
      if (!full_q[wr_bank_q]) begin
        wr_en    = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_idx_q == LastIdx) begin
          full_d[wr_bank_q] = 1'b1;
          wr_bank_d         = ~wr_bank_q;
          frames_wr_d       = frames_wr_q + 1'b1;
        end
      end else begin
        overflow_d = 1'b1;
      end
    end

    // The read side only ever clears rd_bank, which never equals a bank being set this cycle.
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q] && fft_ready_i) begin
          state_d     = StRun;
          fft_start_d = 1'b1;
        end
      end
      StRun: begin
        if (fft_done_i) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          if (frame_cnt_q < NFrameCnt) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
          if (frame_cnt_d == NFrameCnt) begin
            state_d     = StAna;
            ana_start_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StAna: begin
        if (ana_done_i) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      full_q      <= 2'b00;
      frames_wr_q <= '0;
      frame_cnt_q <= 4'd0;
      overflow_q  <= 1'b0;
      fft_start_q <= 1'b0;
      ana_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      full_q      <= full_d;
      frames_wr_q <= frames_wr_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      fft_start_q <= fft_start_d;
      ana_start_q <= ana_start_d;
    end
  end

  assign fft_start_o = fft_start_q;
  assign ana_start_o = ana_start_q;
  assign frame_cnt_o = frame_cnt_q;
  assign overflow_o  = overflow_q;
  assign done_o      = (state_q == StDone);

endmodule
